// File: rtl/regfile_op_sequencer_pkg.sv
// Shared definitions for the regfile op sequencer: op encodings, FSM state
// encodings and default widths.
package regfile_op_sequencer_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 4;

    // Command op encodings (cmd_op)
    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_XNOR  = 2'b10;
    localparam logic [1:0] OP_MOVE  = 2'b11;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RD   = 2'b01;
    localparam logic [1:0] ST_WR   = 2'b10;
    localparam logic [1:0] ST_RSP  = 2'b11;

    // Every op except WRITE needs a regfile read cycle before anything else
    function automatic logic op_needs_read(input logic [1:0] op);
        return (op != OP_WRITE);
    endfunction

endpackage

// File: rtl/regfile_op_sequencer_xnor1.sv
// Single-bit XNOR cell; replicated per data bit to form the XNOR operand.
module xnor1 (
    input  logic a,
    input  logic b,
    output logic y
);

    // y is 1 when both inputs agree
    assign y = ~(a ^ b);

endmodule

// File: rtl/regfile_op_sequencer.sv
// Command sequencer for a 16x4 dual-read regfile. Accepts one op per
// handshake, runs the regfile through a read and/or write cycle and returns
// the result on a response channel.
//
// Handshakes: a command transfers on a rising edge where cmd_valid & cmd_ready
// are both high; a response transfers on a rising edge where rsp_valid &
// rsp_ready are both high. rsp_valid and rsp_* stay stable until that edge,
// and cmd_ready is high only in IDLE, so one op is in flight at a time.
module regfile_op_sequencer
    import regfile_op_sequencer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_src_a,
    input  logic [ADDR_W-1:0] cmd_src_b,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_a,
    output logic [DATA_W-1:0] rsp_b,
    output logic [ADDR_W-1:0] rf_rd_addr1,
    output logic              rf_rd_en1,
    output logic [ADDR_W-1:0] rf_rd_addr2,
    output logic              rf_rd_en2,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic              rf_wr_en,
    output logic [DATA_W-1:0] rf_wr_data,
    input  logic [DATA_W-1:0] rf_dout1,
    input  logic [DATA_W-1:0] rf_dout2,
    output logic [1:0]        dbg_state
);

    logic [1:0]        state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] src_a_q, src_a_d;
    logic [ADDR_W-1:0] src_b_q, src_b_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] opa_q, opa_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_a_q, rsp_a_d;
    logic [DATA_W-1:0] rsp_b_q, rsp_b_d;

    logic [DATA_W-1:0] xnor_res;
    logic [DATA_W-1:0] wr_value;
    logic              in_rd;
    logic              in_wr;

    // Bitwise XNOR of the captured operands
    for (genvar i = 0; i < DATA_W; i++) begin : g_xnor
        xnor1 u_xnor1 (
            .a(opa_q[i]),
            .b(opb_q[i]),
            .y(xnor_res[i])
        );
    end

    // Select the value written in WR; depends only on registered fields
    always_comb begin
        wr_value = opa_q;
        case (op_q)
            OP_WRITE: wr_value = data_q;
            OP_XNOR:  wr_value = xnor_res;
            default:  wr_value = opa_q;
        endcase
    end

    // Decode regfile ports from state; everything is zero while reset is high
    always_comb begin
        in_rd       = (state_q == ST_RD) && !reset;
        in_wr       = (state_q == ST_WR) && !reset;
        rf_rd_en1   = in_rd;
        rf_rd_en2   = in_rd;
        rf_rd_addr1 = in_rd ? src_a_q : '0;
        rf_rd_addr2 = in_rd ? src_b_q : '0;
        rf_wr_en    = in_wr;
        rf_wr_addr  = in_wr ? dst_q : '0;
        rf_wr_data  = in_wr ? wr_value : '0;
    end

    // Next-state, field capture and response generation
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        src_a_d     = src_a_q;
        src_b_d     = src_b_q;
        dst_d       = dst_q;
        data_d      = data_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_a_d     = rsp_a_q;
        rsp_b_d     = rsp_b_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    src_a_d = cmd_src_a;
                    src_b_d = cmd_src_b;
                    dst_d   = cmd_dst;
                    data_d  = cmd_data;
                    state_d = op_needs_read(cmd_op) ? ST_RD : ST_WR;
                end
            end
            ST_RD: begin
                // Operands are captured here, so a src==dst op sees the old value
                opa_d = rf_dout1;
                opb_d = rf_dout2;
                if (op_q == OP_READ) begin
                    state_d     = ST_RSP;
                    rsp_valid_d = 1'b1;
                    rsp_a_d     = rf_dout1;
                    rsp_b_d     = rf_dout2;
                end else begin
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                state_d     = ST_RSP;
                rsp_valid_d = 1'b1;
                rsp_a_d     = wr_value;
                rsp_b_d     = '0;
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and field registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_WRITE;
            src_a_q     <= '0;
            src_b_q     <= '0;
            dst_q       <= '0;
            data_q      <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_a_q     <= '0;
            rsp_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            src_a_q     <= src_a_d;
            src_b_q     <= src_b_d;
            dst_q       <= dst_d;
            data_q      <= data_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_a_q     <= rsp_a_d;
            rsp_b_q     <= rsp_b_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_a     = rsp_a_q;
    assign rsp_b     = rsp_b_q;
    assign dbg_state = state_q;

endmodule
